// File: rtl/mul_pkg.sv
// Shared types and helpers for the vector Vedic multiplier operand path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_pkg;

    typedef enum logic [1:0] {
        MUL   = 2'b00,
        MULH  = 2'b01,
        MULHU = 2'b10,
        MULSU = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        P8  = 2'b00,
        P16 = 2'b01,
        P32 = 2'b10,
        P64 = 2'b11
    } precision_e;

    localparam int LANE_W = 8;

    // Element width in bits for a precision code. Codes wider than the vector
    // collapse to a single element spanning the whole operand.
    function automatic int elem_width(input logic [1:0] precision, input int operand_w);
        int w;
        w = LANE_W << precision;
        return (w > operand_w) ? operand_w : w;
    endfunction

    // Operand A is signed for MUL/MULH/MULSU, operand B only for MUL/MULH.
    function automatic logic is_signed(input logic [1:0] opcode, input int operand_select);
        logic s;
        s = 1'b0;
        if (opcode == MUL || opcode == MULH)
            s = 1'b1;
        else if (opcode == MULSU && operand_select == 0)
            s = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/tc_segmented_negate.sv
// Per-element two's complement of a packed vector (combinational).
// Latency: 0 cycles.
// Backpressure: none, pure function of its inputs.
//
// Ports:
//   operand   packed vector of elements
//   precision element width code (00=8, 01=16, 10=32, 11=64)
//   negated   (~x + 1) of every element, carry confined to each element
module tc_segmented_negate
    import mul_pkg::*;
#(
    parameter int OPERAND_W = 64
) (
    input  logic [OPERAND_W-1:0] operand,
    input  logic [1:0]           precision,
    output logic [OPERAND_W-1:0] negated
);

    localparam int LANES = OPERAND_W / LANE_W;

    // One bit per byte lane: set where a new element begins. The +1 of the
    // negation is injected there instead of the carry from the lane below.
    logic [LANES-1:0] elem_start;

    always_comb begin
        elem_start = '0;
        for (int p = 0; p < 4; p++) begin
            if (precision == 2'(p)) begin
                for (int i = 0; i < LANES; i++) begin
                    elem_start[i] = ((i % (elem_width(2'(p), OPERAND_W) / LANE_W)) == 0);
                end
            end
        end
    end

    always_comb begin
        logic             carry;
        logic [LANE_W:0]  sum;
        negated = '0;
        carry   = 1'b0;
        sum     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (elem_start[i])
                carry = 1'b1;
            sum = {1'b0, ~operand[i*LANE_W +: LANE_W]} + {{LANE_W{1'b0}}, carry};
            negated[i*LANE_W +: LANE_W] = sum[LANE_W-1:0];
            carry = sum[LANE_W];
        end
    end

endmodule

// File: rtl/operand_tc_pipe.sv
// Operand conditioning for the Vedic multiplier: signed negative elements -> magnitude, plus per-lane sign flags.
// Latency: 2 cycles accept-to-out_valid, 1 beat/cycle throughput.
// Backpressure: out_ready low freezes stage 2; stage 1 fills then in_ready drops; no beat lost or duplicated.
//
// Ports:
//   clk, rst_n                        clock (rising) and async active-low reset
//   in_valid/in_ready                 input handshake
//   in_opcode, in_precision           opcode (MUL/MULH/MULHU/MULSU), element width code
//   in_operand                        packed operand vector
//   out_valid/out_ready               output handshake
//   out_operand                       conditioned vector (magnitudes for negated elements)
//   out_sign                          per byte lane: lane belongs to a negated element
//   out_precision, out_opcode         forwarded with the beat
module operand_tc_pipe
    import mul_pkg::*;
#(
    parameter int OPERAND_W      = 64,
    parameter int OPERAND_SELECT = 0,
    localparam int LANES         = OPERAND_W / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_opcode,
    input  logic [1:0]           in_precision,
    input  logic [OPERAND_W-1:0] in_operand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPERAND_W-1:0] out_operand,
    output logic [LANES-1:0]     out_sign,
    output logic [1:0]           out_precision,
    output logic [1:0]           out_opcode
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Stage 1 input side: per-lane sign flags
    // ------------------------------------------------------------------
    logic             sig;
    logic [LANES-1:0] sign_d;

    assign sig = is_signed(in_opcode, OPERAND_SELECT);

    // Each lane looks at the MSB of the element that contains it. The loop
    // over precision codes keeps the lanes-per-element divisor constant in
    // each branch so the lane -> MSB-lane mapping is fixed wiring.
    always_comb begin
        int lpe;
        int msb;
        sign_d = '0;
        lpe    = 1;
        msb    = 0;
        for (int p = 0; p < 4; p++) begin
            if (in_precision == 2'(p)) begin
                lpe = elem_width(2'(p), OPERAND_W) / LANE_W;
                for (int i = 0; i < LANES; i++) begin
                    msb = (i / lpe) * lpe + lpe - 1;
                    if (msb > LANES - 1)
                        msb = LANES - 1;
                    sign_d[i] = sig & in_operand[msb*LANE_W + LANE_W - 1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [OPERAND_W-1:0] s1_operand;
    logic [1:0]           s1_opcode;
    logic [1:0]           s1_precision;
    logic [LANES-1:0]     s1_sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_operand   <= '0;
            s1_opcode    <= '0;
            s1_precision <= '0;
            s1_sign      <= '0;
        end else if (s1_adv) begin
            // An idle input cycle leaves a bubble; data is only refreshed
            // when a real beat arrives.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_operand   <= in_operand;
                s1_opcode    <= in_opcode;
                s1_precision <= in_precision;
                s1_sign      <= sign_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: negate and select per byte lane
    // ------------------------------------------------------------------
    logic [OPERAND_W-1:0] neg_operand;
    logic [OPERAND_W-1:0] cond_operand;

    tc_segmented_negate #(
        .OPERAND_W (OPERAND_W)
    ) u_negate (
        .operand   (s1_operand),
        .precision (s1_precision),
        .negated   (neg_operand)
    );

    // Sign flags are uniform across an element, so a per-lane mux picks
    // the whole element's negated or original value.
    always_comb begin
        cond_operand = s1_operand;
        for (int i = 0; i < LANES; i++) begin
            if (s1_sign[i])
                cond_operand[i*LANE_W +: LANE_W] = neg_operand[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid      <= 1'b0;
            out_operand   <= '0;
            out_sign      <= '0;
            out_precision <= '0;
            out_opcode    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_operand   <= cond_operand;
                out_sign      <= s1_sign;
                out_precision <= s1_precision;
                out_opcode    <= s1_opcode;
            end
        end
    end

endmodule

// File: tb/tb_operand_tc_pipe.sv
module tb_operand_tc_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_opcode;
    logic [1:0]  in_precision;
    logic [63:0] in_operand;
    logic        out_ready;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [31:0] out_operand_a, out_operand_b;
    logic [63:0] out_operand_c;
    logic [3:0]  out_sign_a, out_sign_b;
    logic [7:0]  out_sign_c;
    logic [1:0]  out_prec_a, out_prec_b, out_prec_c;
    logic [1:0]  out_opc_a, out_opc_b, out_opc_c;

    always #5 clk = ~clk;

    // Three configurations share the same input stream.
    operand_tc_pipe #(.OPERAND_W(32), .OPERAND_SELECT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_opcode(in_opcode), .in_precision(in_precision), .in_operand(in_operand[31:0]),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_operand(out_operand_a),
        .out_sign(out_sign_a), .out_precision(out_prec_a), .out_opcode(out_opc_a));

    operand_tc_pipe #(.OPERAND_W(32), .OPERAND_SELECT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_opcode(in_opcode), .in_precision(in_precision), .in_operand(in_operand[31:0]),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_operand(out_operand_b),
        .out_sign(out_sign_b), .out_precision(out_prec_b), .out_opcode(out_opc_b));

    operand_tc_pipe #(.OPERAND_W(64), .OPERAND_SELECT(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_opcode(in_opcode), .in_precision(in_precision), .in_operand(in_operand),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_operand(out_operand_c),
        .out_sign(out_sign_c), .out_precision(out_prec_c), .out_opcode(out_opc_c));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] op_a, op_b, op_c;
        logic [7:0]  sg_a, sg_b, sg_c;
        logic [1:0]  opc, prec;
        int          acc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: split into elements of min(8<<prec, w) bits, negate those
    // that are signed-and-negative modulo 2^ew, flag their bytes.
    function automatic void model(input logic [63:0] op, input int w, input int sel,
                                  input logic [1:0] opc, input logic [1:0] prec,
                                  output logic [63:0] res, output logic [7:0] sgn);
        int          ew;
        logic [63:0] mask;
        logic [63:0] x;
        bit          sg;
        ew   = 8 << prec;
        if (ew > w) ew = w;
        sg   = (opc == 2'b00) || (opc == 2'b01) || (sel == 0 && opc == 2'b11);
        mask = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
        res  = '0;
        sgn  = '0;
        for (int e = 0; e * ew < w; e++) begin
            x = (op >> (e * ew)) & mask;
            if (sg && x[ew-1]) begin
                x = (64'd0 - x) & mask;
                for (int l = 0; l < ew / 8; l++) sgn[e * (ew / 8) + l] = 1'b1;
            end
            res = res | (x << (e * ew));
        end
    endfunction

    // One clock cycle: drive at the falling edge, check shortly after, and
    // update the scoreboard for the handshakes that will fire at the next
    // rising edge.
    task automatic step(input logic iv, input logic [1:0] opc, input logic [1:0] prec,
                        input logic [63:0] op, input logic ordy, output bit accepted);
        logic exp_rdy, exp_vld;
        exp_t e;
        @(negedge clk);
        cyc++;
        in_valid = iv; in_opcode = opc; in_precision = prec; in_operand = op; out_ready = ordy;
        #1;
        exp_rdy = (q.size() < 2) || ordy;
        exp_vld = (q.size() > 0) && (cyc >= q[0].acc + 2);
        chk("in_ready_a", {63'd0, in_ready_a}, {63'd0, exp_rdy});
        chk("in_ready_b", {63'd0, in_ready_b}, {63'd0, exp_rdy});
        chk("in_ready_c", {63'd0, in_ready_c}, {63'd0, exp_rdy});
        chk("out_valid_a", {63'd0, out_valid_a}, {63'd0, exp_vld});
        chk("out_valid_b", {63'd0, out_valid_b}, {63'd0, exp_vld});
        chk("out_valid_c", {63'd0, out_valid_c}, {63'd0, exp_vld});
        if (exp_vld) begin
            chk("operand_a", {32'd0, out_operand_a}, q[0].op_a);
            chk("operand_b", {32'd0, out_operand_b}, q[0].op_b);
            chk("operand_c", out_operand_c, q[0].op_c);
            chk("sign_a", {60'd0, out_sign_a}, {56'd0, q[0].sg_a});
            chk("sign_b", {60'd0, out_sign_b}, {56'd0, q[0].sg_b});
            chk("sign_c", {56'd0, out_sign_c}, {56'd0, q[0].sg_c});
            chk("opcode_b", {62'd0, out_opc_b}, {62'd0, q[0].opc});
            chk("precision_c", {62'd0, out_prec_c}, {62'd0, q[0].prec});
            if (ordy) void'(q.pop_front());
        end
        accepted = iv && exp_rdy;
        if (accepted) begin
            model(op & 64'h0000_0000_FFFF_FFFF, 32, 0, opc, prec, e.op_a, e.sg_a);
            model(op & 64'h0000_0000_FFFF_FFFF, 32, 1, opc, prec, e.op_b, e.sg_b);
            model(op, 64, 0, opc, prec, e.op_c, e.sg_c);
            e.opc  = opc;
            e.prec = prec;
            e.acc  = cyc;
            q.push_back(e);
        end
    endtask

    // Send one beat into an idle pipe and leave it on the outputs.
    task automatic beat(input logic [1:0] opc, input logic [1:0] prec, input logic [63:0] op);
        bit acc;
        step(1'b1, opc, prec, op, 1'b1, acc);
        step(1'b0, 2'b00, 2'b00, 64'd0, 1'b1, acc);
        step(1'b0, 2'b00, 2'b00, 64'd0, 1'b1, acc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          sent;
        logic [63:0] op;
        logic        ordy;

        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 2'b00; in_precision = 2'b00;
        in_operand = 64'd0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid_a", {63'd0, out_valid_a}, 64'd0);
        chk("rst_out_valid_c", {63'd0, out_valid_c}, 64'd0);
        chk("rst_operand_c", out_operand_c, 64'd0);
        chk("rst_sign_c", {56'd0, out_sign_c}, 64'd0);
        chk("rst_prec_opc_a", {60'd0, out_prec_a, out_opc_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_a", {63'd0, in_ready_a}, 64'd1);

        // Byte elements, opcode MUL
        beat(2'b00, 2'b00, 64'h0000_0000_7F80_FF01);
        chk("tp1_operand_a", {32'd0, out_operand_a}, 64'h7F80_0101);
        chk("tp1_sign_a", {60'd0, out_sign_a}, 64'h6);

        // MULSU: operand B unsigned, operand A signed
        beat(2'b11, 2'b10, 64'h0000_0000_FFFF_FFFE);
        chk("tp2_operand_b", {32'd0, out_operand_b}, 64'hFFFF_FFFE);
        chk("tp2_sign_b", {60'd0, out_sign_b}, 64'h0);
        chk("tp2_operand_a", {32'd0, out_operand_a}, 64'h0000_0002);
        beat(2'b01, 2'b10, 64'h0000_0000_FFFF_FFFE);
        chk("tp3_operand_b", {32'd0, out_operand_b}, 64'h0000_0002);
        chk("tp3_sign_b", {60'd0, out_sign_b}, 64'hF);

        // 64-bit most-negative value; 32-bit lanes saturate precision 11
        beat(2'b00, 2'b11, 64'h8000_0000_8000_0001);
        chk("tp4_operand_c", out_operand_c, 64'h7FFF_FFFF_7FFF_FFFF);
        chk("tp4_operand_a", {32'd0, out_operand_a}, 64'h7FFF_FFFF);
        beat(2'b00, 2'b11, 64'h8000_0000_0000_0000);
        chk("tp5_operand_c", out_operand_c, 64'h8000_0000_0000_0000);
        chk("tp5_sign_c", {56'd0, out_sign_c}, 64'hFF);
        beat(2'b00, 2'b01, 64'hFFFF_0000_8000_0001);
        chk("tp6_operand_c", out_operand_c, 64'h0001_0000_8000_0001);
        chk("tp6_sign_c", {56'd0, out_sign_c}, 64'hCC);
        beat(2'b00, 2'b00, 64'h0000_0000_0000_0080);
        chk("tp7_min8_a", {32'd0, out_operand_a}, 64'h0000_0080);
        chk("tp7_sign_a", {60'd0, out_sign_a}, 64'h1);

        // Backpressure: 4 beats, out_ready low for cycles 3..6
        sent = 0;
        for (int k = 1; k <= 14; k++) begin
            ordy = !(k >= 3 && k <= 6);
            op   = {$urandom, $urandom};
            step(sent < 4, 2'(sent), 2'b00, op, ordy, acc);
            if (acc) sent++;
            if (k == 6) chk("bp_in_ready_stalled", {63'd0, in_ready_a}, 64'd0);
        end
        chk("bp_all_sent", 64'(sent), 64'd4);

        // Back-to-back alternating precision
        for (int k = 0; k < 8; k++)
            step(1'b1, 2'b00, 2'(k % 2), {$urandom, $urandom} | 64'h8080_8080_8080_8080, 1'b1, acc);
        for (int k = 0; k < 3; k++)
            step(1'b0, 2'b00, 2'b00, 64'd0, 1'b1, acc);

        // Reset with two beats in flight
        step(1'b1, 2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, acc);
        step(1'b1, 2'b01, 2'b01, 64'h8000_8000_8000_8000, 1'b1, acc);
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid", {63'd0, out_valid_c}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid_a", {63'd0, out_valid_a}, 64'd0);
        chk("async_rst_valid_b", {63'd0, out_valid_b}, 64'd0);
        chk("async_rst_valid_c", {63'd0, out_valid_c}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++)
            step(1'b0, 2'b00, 2'b00, 64'd0, 1'b1, acc);
        beat(2'b00, 2'b10, 64'h1234_5678_9ABC_DEF0);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 7))
                0:       op = 64'd0;
                1:       op = 64'hFFFF_FFFF_FFFF_FFFF;
                2:       op = 64'h8080_8080_8080_8080;
                3:       op = 64'h8000_8000_8000_8000;
                default: op = {$urandom, $urandom};
            endcase
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 op, $urandom_range(0, 2) != 0, acc);
        end
        for (int k = 0; k < 6; k++)
            step(1'b0, 2'b00, 2'b00, 64'd0, 1'b1, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
